// File: rtl/vend_sequencer.sv
// Vending controller: coin credit, product selection, dispense handshake,
// 5-rupee change stream and per-slot stock tracking.
module vend_sequencer #(
  parameter int PRICE0     = 15,
  parameter int PRICE1     = 20,
  parameter int PRICE2     = 25,
  parameter int PRICE3     = 10,
  parameter int MAX_CREDIT = 50,
  parameter int TIMEOUT    = 16,
  parameter int STOCK_INIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] coin,
  input  logic       sel_valid,
  input  logic [1:0] sel,
  input  logic       cancel,
  input  logic       restock,
  input  logic       vend_ack,
  input  logic       chg_ack,
  output logic [5:0] credit,
  output logic       vend_req,
  output logic [1:0] vend_id,
  output logic       chg_req,
  output logic       coin_reject,
  output logic [3:0] sold_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    stock [4];
  logic [6:0]    val;
  logic [6:0]    sum;
  logic [6:0]    price_sel;
  logic [6:0]    price_vid;
  logic [5:0]    left;
  logic          coin_ok;
  logic          sel_ok;

  function automatic logic [6:0] price(input logic [1:0] s);
    unique case (s)
      2'd0:    price = 7'(PRICE0);
      2'd1:    price = 7'(PRICE1);
      2'd2:    price = 7'(PRICE2);
      default: price = 7'(PRICE3);
    endcase
  endfunction

  always_comb begin
    val = 7'd0;
    unique case (coin)
      2'b01:   val = 7'd5;
      2'b10:   val = 7'd10;
      default: val = 7'd0;
    endcase
  end

  assign coin_ok   = (coin == 2'b01) || (coin == 2'b10);
  assign sum       = {1'b0, credit} + val;
  assign price_sel = price(sel);
  assign price_vid = price(vend_id);
  assign left      = credit - price_vid[5:0];
  assign sel_ok    = sel_valid
                  && ({1'b0, credit} >= price_sel)
                  && (stock[sel] != 3'd0);

  always_comb begin
    sold_out = 4'd0;
    for (int i = 0; i < 4; i++)
      sold_out[i] = (stock[i] == 3'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      credit      <= 6'd0;
      timer       <= '0;
      vend_req    <= 1'b0;
      vend_id     <= 2'd0;
      chg_req     <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < 4; i++)
        stock[i] <= 3'(STOCK_INIT);
    end else begin
      coin_reject <= 1'b0;
      unique case (state)
        IDLE: begin
          if (restock)
            for (int i = 0; i < 4; i++)
              stock[i] <= 3'(STOCK_INIT);
          if (coin_ok) begin
            credit <= sum[5:0];
            timer  <= '0;
            state  <= CREDIT;
          end else if (coin == 2'b11) begin
            coin_reject <= 1'b1;
          end
        end
        CREDIT: begin
          priority case (1'b1)
            cancel: begin
              coin_reject <= (coin != 2'b00);
              chg_req     <= (credit != 6'd0);
              busy        <= 1'b1;
              timer       <= '0;
              state       <= CHANGE;
            end
            (coin != 2'b00): begin
              timer <= '0;
              if (coin_ok && sum <= 7'(MAX_CREDIT))
                credit <= sum[5:0];
              else
                coin_reject <= 1'b1;
            end
            sel_ok: begin
              vend_id  <= sel;
              vend_req <= 1'b1;
              busy     <= 1'b1;
              timer    <= '0;
              state    <= VEND;
            end
            default: begin
              // Rejected selections still count as idle cycles.
              if (timer == TW'(TIMEOUT - 1)) begin
                chg_req <= (credit != 6'd0);
                busy    <= 1'b1;
                timer   <= '0;
                state   <= CHANGE;
              end else begin
                timer <= timer + 1'b1;
              end
            end
          endcase
        end
        VEND: begin
          coin_reject <= (coin != 2'b00);
          if (vend_ack) begin
            credit         <= left;
            stock[vend_id] <= stock[vend_id] - 3'd1;
            vend_req       <= 1'b0;
            if (left != 6'd0) begin
              chg_req <= 1'b1;
              state   <= CHANGE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        CHANGE: begin
          coin_reject <= (coin != 2'b00);
          if (credit == 6'd0) begin
            chg_req <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (chg_ack) begin
            credit <= credit - 6'd5;
            if (credit == 6'd5) begin
              chg_req <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios then random traffic,
// every cycle compared against a behavioural vending model.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic       vend_ack = 1'b0;
  logic       chg_ack = 1'b0;
  logic [5:0] credit;
  logic       vend_req;
  logic [1:0] vend_id;
  logic       chg_req;
  logic       coin_reject;
  logic [3:0] sold_out;
  logic       busy;

  int errors = 0;
  int checks = 0;

  vend_sequencer dut (
    .clk(clk), .reset(reset), .coin(coin),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .restock(restock), .vend_ack(vend_ack), .chg_ack(chg_ack),
    .credit(credit), .vend_req(vend_req), .vend_id(vend_id),
    .chg_req(chg_req), .coin_reject(coin_reject),
    .sold_out(sold_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: what the machine is doing, not how.
  localparam int M_IDLE = 10, M_PAY = 11, M_DISP = 12, M_REFUND = 13;
  int prices [4] = '{15, 20, 25, 10};
  int m_mode, m_cr, m_vid, m_idle, m_rej;
  int m_stock [4];

  task automatic model_reset();
    m_mode = M_IDLE; m_cr = 0; m_vid = 0; m_idle = 0; m_rej = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 3;
  endtask

  task automatic model_step();
    int v;
    v = (coin == 2'b01) ? 5 : (coin == 2'b10) ? 10 : 0;
    m_rej = 0;
    case (m_mode)
      M_IDLE: begin
        if (restock) for (int i = 0; i < 4; i++) m_stock[i] = 3;
        if (v != 0) begin m_cr += v; m_mode = M_PAY; m_idle = 0; end
        else if (coin == 2'b11) m_rej = 1;
      end
      M_PAY: begin
        if (cancel) begin
          m_rej = (coin != 0); m_mode = M_REFUND;
        end else if (coin != 0) begin
          m_idle = 0;
          if (v != 0 && m_cr + v <= 50) m_cr += v; else m_rej = 1;
        end else if (sel_valid && m_cr >= prices[sel] && m_stock[sel] > 0) begin
          m_vid = sel; m_mode = M_DISP;
        end else begin
          m_idle++;
          if (m_idle == 16) m_mode = M_REFUND;
        end
      end
      M_DISP: begin
        m_rej = (coin != 0);
        if (vend_ack) begin
          m_cr -= prices[m_vid];
          m_stock[m_vid]--;
          m_mode = (m_cr > 0) ? M_REFUND : M_IDLE;
        end
      end
      default: begin
        m_rej = (coin != 0);
        if (chg_ack && m_cr > 0) m_cr -= 5;
        if (m_cr == 0) m_mode = M_IDLE;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [3:0] so;
    for (int i = 0; i < 4; i++) so[i] = (m_stock[i] == 0);
    chk("credit", 32'(credit), 32'(m_cr));
    chk("vend_req", 32'(vend_req), 32'(m_mode == M_DISP));
    chk("vend_id", 32'(vend_id), 32'(m_vid));
    chk("chg_req", 32'(chg_req), 32'(m_mode == M_REFUND && m_cr > 0));
    chk("coin_reject", 32'(coin_reject), 32'(m_rej));
    chk("busy", 32'(busy), 32'(m_mode == M_DISP || m_mode == M_REFUND));
    chk("sold_out", 32'(sold_out), 32'(so));
  endtask

  // Drive one cycle of inputs, advance the model, compare after the edge.
  task automatic tick(input logic [1:0] c = 2'b00, input logic sv = 1'b0,
                      input logic [1:0] s = 2'd0, input logic cn = 1'b0,
                      input logic rs = 1'b0, input logic va = 1'b0,
                      input logic ca = 1'b0);
    coin = c; sel_valid = sv; sel = s; cancel = cn;
    restock = rs; vend_ack = va; chg_ack = ca;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    chk("reset_credit", 32'(credit), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Simple exact-price vend of slot 0
    tick(2'b01);
    tick(2'b10);
    chk("t1_credit15", 32'(credit), 32'd15);
    tick(2'b00, 1'b1, 2'd0);
    chk("t1_vreq", 32'(vend_req), 32'd1);
    tick(); tick(); tick();
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("t1_credit0", 32'(credit), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    tick();
    chk("t1_nochg", 32'(chg_req), 32'd0);

    // Overpay then one change coin
    tick(2'b10); tick(2'b10);
    tick(2'b00, 1'b1, 2'd0);
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("t2_credit5", 32'(credit), 32'd5);
    chk("t2_chgreq", 32'(chg_req), 32'd1);
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_done", 32'(chg_req), 32'd0);

    // Unaffordable selection, then timeout refund
    tick(2'b10);
    tick(2'b00, 1'b1, 2'd2);
    chk("t3_ignored", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) tick();
    chk("t3_refund", 32'(chg_req), 32'd1);
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_idle", 32'(busy), 32'd0);

    // Credit ceiling, invalid coin, coin during vend
    for (int i = 0; i < 5; i++) tick(2'b10);
    chk("t4_credit50", 32'(credit), 32'd50);
    tick(2'b01);
    chk("t4_ceiling_rej", 32'(coin_reject), 32'd1);
    tick(2'b11);
    chk("t4_invalid_rej", 32'(coin_reject), 32'd1);
    tick(2'b00, 1'b1, 2'd3);
    tick(2'b01);
    chk("t4_vend_rej", 32'(coin_reject), 32'd1);
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Drain slot 3 and restock
    for (int k = 0; k < 2; k++) begin
      tick(2'b10);
      tick(2'b00, 1'b1, 2'd3);
      tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    end
    chk("t5_soldout", 32'(sold_out), 32'h8);
    tick(2'b10);
    tick(2'b00, 1'b1, 2'd3);
    chk("t5_sel_ignored", 32'(vend_req), 32'd0);
    tick(2'b00, 1'b0, 2'd0, 1'b1);
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("t5_restocked", 32'(sold_out), 32'h0);

    // Asynchronous reset in the middle of a vend
    tick(2'b10); tick(2'b10);
    tick(2'b00, 1'b1, 2'd1);
    chk("t6_vreq", 32'(vend_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("t6_async_credit", 32'(credit), 32'd0);
    chk("t6_async_vreq", 32'(vend_req), 32'd0);
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    // Cancel with a simultaneous coin refunds prior credit only
    tick(2'b01);
    tick(2'b10, 1'b0, 2'd0, 1'b1);
    chk("t6_cancel_rej", 32'(coin_reject), 32'd1);
    chk("t6_cancel_cr", 32'(credit), 32'd5);
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] c;
      c = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick(c, ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Multi-product vending controller. Accumulates 5/10 rupee coins into a credit register and accepts a product selection. It sequences a dispense handshake with the product motor, then pays change as a stream of 5-rupee coins through a coin-changer handshake. It sits between the coin acceptor/keypad front end and the motor/changer drivers, and tracks per-slot stock.

Parameters:
PRICE0, 15, price of slot 0 in rupees (multiple of 5)
PRICE1, 20, price of slot 1
PRICE2, 25, price of slot 2
PRICE3, 10, price of slot 3
MAX_CREDIT, 50, credit ceiling in rupees (multiple of 5, <=60)
TIMEOUT, 16, idle cycles in CREDIT before automatic refund
STOCK_INIT, 3, items per slot after reset/restock (<=7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
coin  input  2  00 none, 01 = 5 rs, 10 = 10 rs, 11 = invalid; one coin per cycle
sel_valid  input  1  selection strobe, one cycle
sel  input  2  slot index, valid with sel_valid
cancel  input  1  refund request, one cycle
restock  input  1  reload all slots to STOCK_INIT
vend_ack  input  1  motor done, completes the dispense handshake
chg_ack  input  1  changer has ejected one 5 rs coin
credit  output  6  current credit in rupees
vend_req  output  1  dispense request, held until vend_ack
vend_id  output  2  slot being dispensed, stable while vend_req
chg_req  output  1  request one 5 rs coin, held while credit>0 in CHANGE
coin_reject  output  1  one-cycle pulse: coin returned, not credited
sold_out  output  4  bit i set when stock[i]==0
busy  output  1  high in VEND or CHANGE

Behaviour:
- Reset (reset=0, async): state IDLE; credit=0; all stock=STOCK_INIT; vend_req, chg_req, coin_reject, busy = 0; timer = 0. Credit held at reset is lost.
- FSM states: IDLE, CREDIT, VEND, CHANGE. All outputs are registered. credit updates one cycle after the accepting edge.
- IDLE:
  - Valid coin: credit += value; go to CREDIT.
  - sel_valid / cancel ignored.
  - restock honoured only in IDLE.
- CREDIT, priority cancel > coin > sel:
  - cancel: go to CHANGE. A coin in the same cycle is rejected.
  - Valid coin: credit += value if credit+value <= MAX_CREDIT, else coin_reject. Timer cleared on any coin activity. sel ignored that cycle.
  - sel_valid with credit >= PRICE[sel] and stock[sel] != 0: latch vend_id=sel; go to VEND.
  - sel_valid that fails either check is ignored; state and credit unchanged.
  - Timer counts cycles with no coin, cancel or accepted sel. At TIMEOUT go to CHANGE (refund).
- VEND:
  - vend_req=1, vend_id stable.
  - On the vend_ack cycle: credit -= PRICE[vend_id]; stock[vend_id] -= 1; vend_req drops next cycle.
  - Next state is CHANGE if the remaining credit is > 0, else IDLE.
  - No timeout here; vend_req is held indefinitely. cancel ignored.
- CHANGE:
  - chg_req=1 while credit>0.
  - Each cycle with chg_ack=1: credit -= 5.
  - When credit reaches 0: chg_req=0; go to IDLE.
  - chg_ack with chg_req=0 is ignored.
- Coins in VEND or CHANGE: coin_reject pulse, credit unchanged. coin=11 is always rejected.
- vend_ack outside VEND is ignored.
- Stock never underflows: the sel check prevents it. sold_out is derived combinationally from the registered stock.
- Arithmetic is unsigned. credit is never negative because prices are validated before VEND.

Test Plan:
- Reset, then 5 rs, 10 rs, sel=0, vend_ack after 3 cycles -> credit 15, vend_req with vend_id=0, credit 0 after ack, return to IDLE, chg_req never asserted, stock0=2.
- 10, 10, sel=0 (price 15), ack; then chg_ack -> credit 20 -> 5 after vend; exactly one chg_req/chg_ack pair; credit 0; IDLE.
- 10 rs, sel=2 (price 25) -> ignored, stays CREDIT with credit 10. Then 16 idle cycles -> CHANGE; two chg_ack pulses refund 10; IDLE.
- Five 10 rs coins, then 5 rs -> credit 50, 6th coin gives coin_reject; coin=11 always rejected; coin during VEND rejected.
- Vend slot 3 three times (10 rs each) -> sold_out=4'b1000; next sel=3 ignored. restock in IDLE -> sold_out=0.
- reset asserted mid-VEND with credit 20 -> vend_req=0, credit=0, IDLE immediately (async). Cancel with a coin in the same cycle -> coin_reject, refund of prior credit only.
